// File: rtl/w_mem_access_sched_pkg.sv
// w_mem_access_sched_pkg: shared defaults, FSM state and row type for the weight-memory scheduler.
package w_mem_access_sched_pkg;
    localparam int DEF_ADDR_W     = 14;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ROW_WORDS  = 4;
    localparam int DEF_LEN_W      = 12;
    localparam int DEF_STARVE_MAX = 8;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;
    typedef logic [DEF_ROW_WORDS*DEF_DATA_W-1:0] row_t;
endpackage

// File: rtl/w_mem_skid_fifo.sv
// w_mem_skid_fifo: 2-entry FIFO absorbing the SRAM read latency so the consumer can stall.
module w_mem_skid_fifo
    import w_mem_access_sched_pkg::*;
#(
    parameter int W = $bits(row_t)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_wp, r_rp;
    logic [1:0]   r_count;

    always_ff @(posedge clk)
        if (i_push) r_mem[r_wp] <= i_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wp <= ~r_wp;
            if (i_pop) r_rp <= ~r_rp;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_data  = r_mem[r_rp];
    assign o_count = r_count;
endmodule

// File: rtl/w_mem_access_sched.sv
// w_mem_access_sched: shares the single-port weight SRAM between loader writes and strided
// streaming read bursts, keeping rd/wr enables mutually exclusive.
module w_mem_access_sched
    import w_mem_access_sched_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ROW_WORDS  = DEF_ROW_WORDS,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_start,
    input  logic [ADDR_W-1:0]             cfg_base,
    input  logic [LEN_W-1:0]              cfg_len,
    input  logic [ADDR_W-1:0]             cfg_stride,
    output logic                          busy,
    output logic                          done,
    input  logic                          wr_req_valid,
    output logic                          wr_req_ready,
    input  logic [ADDR_W-1:0]             wr_req_addr,
    input  logic [ROW_WORDS*DATA_W-1:0]   wr_req_data,
    output logic                          rd_out_valid,
    input  logic                          rd_out_ready,
    output logic [ROW_WORDS*DATA_W-1:0]   rd_out_data,
    output logic                          mem_rd_enable,
    output logic [ADDR_W-1:0]             mem_rd_addr,
    output logic                          mem_wr_enable,
    output logic [ADDR_W-1:0]             mem_wr_addr,
    output logic [ROW_WORDS*DATA_W-1:0]   mem_wr_data,
    input  logic [ROW_WORDS*DATA_W-1:0]   mem_rd_data
);
    localparam int ROW_W = ROW_WORDS * DATA_W;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr, r_stride;
    logic [LEN_W-1:0]  r_rem;
    logic [SW-1:0]     r_starve;
    logic              r_inflight, r_done;
    logic [1:0]        w_count;
    logic [ROW_W-1:0]  w_head;
    logic              w_grant, w_pop, w_issue, w_fin;

    assign w_grant = reset && wr_req_valid && (r_state != S_STREAM || r_starve == SW'(STARVE_MAX));
    assign w_pop   = rd_out_valid && rd_out_ready;
    // Credit counts this cycle's pop so an unstalled consumer gets a row every cycle.
    assign w_issue = r_state == S_STREAM && !w_grant &&
                     ({1'b0, w_count} - {2'b0, w_pop} + {2'b0, r_inflight}) < 3'd2;
    assign w_fin   = r_state == S_DRAIN && !r_inflight && w_count == {1'b0, w_pop};

    w_mem_skid_fifo #(.W(ROW_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_data  (mem_rd_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_stride   <= '0;
            r_rem      <= '0;
            r_starve   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= w_fin || (r_state == S_IDLE && cfg_start && cfg_len == '0);
            r_starve   <= w_grant ? '0 :
                          (wr_req_valid && r_starve != SW'(STARVE_MAX)) ? r_starve + 1'b1 : r_starve;
            case (r_state)
                S_IDLE: if (cfg_start) begin
                    r_addr   <= cfg_base;
                    r_rem    <= cfg_len;
                    r_stride <= cfg_stride;
                    if (cfg_len != '0) r_state <= S_STREAM;
                end
                S_STREAM: if (w_issue) begin
                    r_addr <= r_addr + r_stride;
                    r_rem  <= r_rem - 1'b1;
                    if (r_rem == LEN_W'(1)) r_state <= S_DRAIN;
                end
                S_DRAIN: if (w_fin) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_state != S_IDLE;
    assign done          = r_done;
    assign wr_req_ready  = w_grant;
    assign mem_wr_enable = w_grant;
    assign mem_wr_addr   = wr_req_addr;
    assign mem_wr_data   = w_grant ? wr_req_data : '0;
    assign mem_rd_enable = w_issue;
    assign mem_rd_addr   = r_addr;
    assign rd_out_valid  = w_count != 2'd0;
    assign rd_out_data   = w_head;
endmodule

// File: tb/tb_w_mem_access_sched.sv
// tb_w_mem_access_sched: randomized and directed stimulus checked every cycle against a queue-based model.
module tb_w_mem_access_sched;
    localparam int AW = 14, RW = 32, LW = 12, SMAX = 8;
    localparam int M_IDLE = 0, M_STREAM = 1, M_DRAIN = 2;

    logic          clk = 0, reset = 0;
    logic          cfg_start = 0;
    logic [AW-1:0] cfg_base = '0, cfg_stride = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          busy, done;
    logic          wr_req_valid = 0, wr_req_ready;
    logic [AW-1:0] wr_req_addr = '0;
    logic [RW-1:0] wr_req_data = '0;
    logic          rd_out_valid, rd_out_ready = 0;
    logic [RW-1:0] rd_out_data;
    logic          mem_rd_enable, mem_wr_enable;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [RW-1:0] mem_wr_data, mem_rd_data;

    always #5 clk = ~clk;

    w_mem_access_sched dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .cfg_stride(cfg_stride), .busy(busy), .done(done), .wr_req_valid(wr_req_valid),
        .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .rd_out_valid(rd_out_valid), .rd_out_ready(rd_out_ready), .rd_out_data(rd_out_data),
        .mem_rd_enable(mem_rd_enable), .mem_rd_addr(mem_rd_addr), .mem_wr_enable(mem_wr_enable),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    function automatic logic [RW-1:0] sram(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'hA5, a[13:6], ~a[7:0], 2'b01, a[13:8]};
    endfunction

    // Read-only SRAM stand-in: one-cycle latency, garbage when not reading.
    always @(posedge clk) mem_rd_data <= mem_rd_enable ? sram(mem_rd_addr) : RW'($urandom);

    int n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0;
    logic [AW-1:0] rd_log[$];
    int rd_cyc[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: burst descriptor, starvation count, in-flight address and a row queue.
    int            m_mode = M_IDLE, m_rem = 0, m_starve = 0;
    logic [AW-1:0] m_addr = '0, m_stride = '0, m_infl_addr = '0;
    bit            m_infl = 0, m_done = 0;
    logic [RW-1:0] q[$];

    initial forever begin
        bit g, pop, iss, fin;
        @(negedge clk);
        cyc++;
        chk("excl", {63'd0, mem_rd_enable & mem_wr_enable}, 0);
        if (mem_rd_enable) begin rd_log.push_back(mem_rd_addr); rd_cyc.push_back(cyc); end
        if (done) done_cnt++;
        if (!reset) begin
            chk("rst_outs", {busy, done, rd_out_valid, mem_rd_enable, mem_wr_enable, wr_req_ready}, 0);
            chk("rst_wdata", mem_wr_data, 0);
            m_mode = M_IDLE; m_rem = 0; m_starve = 0; m_infl = 0; m_done = 0; q.delete();
        end else begin
            g   = wr_req_valid && (m_mode != M_STREAM || m_starve == SMAX);
            pop = q.size() > 0 && rd_out_ready;
            iss = m_mode == M_STREAM && !g && (q.size() - int'(pop) + int'(m_infl) < 2);
            chk("busy", busy, m_mode != M_IDLE);
            chk("done", done, m_done);
            chk("wr_ready", wr_req_ready, g);
            chk("wr_en", mem_wr_enable, g);
            chk("wr_data", mem_wr_data, g ? wr_req_data : '0);
            if (g) chk("wr_addr", mem_wr_addr, wr_req_addr);
            chk("rd_en", mem_rd_enable, iss);
            if (iss) chk("rd_addr", mem_rd_addr, m_addr);
            chk("out_valid", rd_out_valid, q.size() > 0);
            if (q.size() > 0) chk("out_data", rd_out_data, q[0]);
            if (pop) void'(q.pop_front());
            if (m_infl) q.push_back(sram(m_infl_addr));
            fin      = m_mode == M_DRAIN && !m_infl && q.size() == 0;
            m_done   = (m_mode == M_IDLE && cfg_start && cfg_len == 0) || fin;
            m_starve = g ? 0 : (wr_req_valid && m_starve < SMAX) ? m_starve + 1 : m_starve;
            m_infl      = iss;
            m_infl_addr = m_addr;
            if (m_mode == M_IDLE && cfg_start) begin
                m_addr = cfg_base; m_stride = cfg_stride; m_rem = int'(cfg_len);
                if (cfg_len != 0) m_mode = M_STREAM;
            end else if (m_mode == M_STREAM && iss) begin
                m_addr = m_addr + m_stride;
                m_rem--;
                if (m_rem == 0) m_mode = M_DRAIN;
            end else if (fin) m_mode = M_IDLE;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            wr_req_addr = AW'($urandom);
            wr_req_data = $urandom;
        end
    endtask

    task automatic start(input logic [AW-1:0] b, input int l, input logic [AW-1:0] s);
        cfg_base = b; cfg_len = LW'(l); cfg_stride = s; cfg_start = 1;
        step();
        cfg_start = 0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 500) begin step(); k++; end
        chk(nm, busy, 0);
        step(2);
    endtask

    initial begin
        int gk;
        wr_req_valid = 1;
        step(3);
        reset = 1; wr_req_valid = 0;
        step(2);

        rd_out_ready = 1; rd_log.delete(); rd_cyc.delete(); done_cnt = 0;
        start(14'h010, 4, 14'd4);
        wait_idle("t1_idle");
        chk("t1_n", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            chk("t1_a0", rd_log[0], 14'h010);
            chk("t1_a1", rd_log[1], 14'h014);
            chk("t1_a2", rd_log[2], 14'h018);
            chk("t1_a3", rd_log[3], 14'h01C);
            chk("t1_back2back", rd_cyc[3] - rd_cyc[0], 3);
        end
        chk("t1_done", done_cnt, 1);

        rd_out_ready = 0; rd_log.delete();
        start(14'h010, 4, 14'd4);
        step(5);
        chk("t2_stalled_reads", rd_log.size(), 2);
        chk("t2_valid_held", rd_out_valid, 1);
        rd_out_ready = 1;
        wait_idle("t2_idle");
        chk("t2_n", rd_log.size(), 4);

        wr_req_valid = 1; gk = 0;
        start(14'h100, 20, 14'd1);
        for (int k = 1; k <= 40 && gk == 0; k++) begin
            @(negedge clk);
            if (wr_req_ready) begin gk = k; chk("t3_rd_off", mem_rd_enable, 0); end
            step();
        end
        chk("t3_grant_cycle", gk, 9);
        wait_idle("t3_idle");
        wr_req_valid = 0;

        rd_log.delete();
        start(14'h055, 0, 14'd1);
        chk("t4_done", {busy, done}, 2'b01);
        step();
        chk("t4_done_off", {busy, done}, 2'b00);
        chk("t4_no_reads", rd_log.size(), 0);

        rd_log.delete();
        start(14'h3FFC, 2, 14'd4);
        wait_idle("t5_idle");
        chk("t5_n", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            chk("t5_a0", rd_log[0], 14'h3FFC);
            chk("t5_a1", rd_log[1], 14'h0000);
        end

        rd_out_ready = 0;
        start(14'h200, 8, 14'd1);
        step(4);
        chk("t6_buffered", rd_out_valid, 1);
        reset = 0; wr_req_valid = 1;
        #1;
        chk("t6_rst_now", {busy, done, rd_out_valid, mem_rd_enable, mem_wr_enable, wr_req_ready}, 0);
        step(2);
        reset = 1; wr_req_valid = 0; rd_out_ready = 1;
        step();
        rd_log.delete();
        start(14'h300, 3, 14'd2);
        wait_idle("t6_idle");
        chk("t6_n", rd_log.size(), 3);

        for (int k = 0; k < 400; k++) begin
            rd_out_ready = ($urandom % 4) != 0;
            wr_req_valid = ($urandom % 3) == 0;
            cfg_start    = ($urandom % 8) == 0;
            cfg_len      = LW'($urandom % 7);
            cfg_base     = AW'($urandom);
            cfg_stride   = AW'($urandom);
            step();
        end
        cfg_start = 0; wr_req_valid = 0; rd_out_ready = 1;
        wait_idle("t7_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/w_mem_access_sched.md
Name: w_mem_access_sched

Overview:
- Sequences and shares the weight-memory SRAM wrapper between two requesters: the weight loader (writes) and the PE-array weight streamer (reads).
- The wrapper has one port, muxed on wr_enable. This block guarantees rd_enable and wr_enable are never both high.
- It generates strided read bursts from a programmed descriptor and absorbs the SRAM's 1-cycle read latency into a 2-entry output buffer, so the consumer may backpressure.
- Sits between the layer controller / weight DMA and the weight-memory wrapper.

Parameters:
ADDR_W, 14, word address width of the wrapper (column + bank-row + subblock bits)
DATA_W, 8, bits per weight byte lane
ROW_WORDS, 4, byte lanes per memory row (wrapper blocks_per_row)
LEN_W, 12, burst length counter width (rows)
STARVE_MAX, 8, stalled-write cycles before a write preempts the stream

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
cfg_start  in  1  start burst pulse; sampled only in IDLE
cfg_base  in  ADDR_W  first read address
cfg_len  in  LEN_W  number of rows to read
cfg_stride  in  ADDR_W  address increment per row
busy  out  1  high while not IDLE
done  out  1  1-cycle pulse at burst completion
wr_req_valid  in  1  loader write request
wr_req_ready  out  1  write accepted this cycle (combinational grant)
wr_req_addr  in  ADDR_W  write address
wr_req_data  in  ROW_WORDS*DATA_W  write row, lane i at bits [i*DATA_W +: DATA_W]
rd_out_valid  out  1  streamed row available
rd_out_ready  in  1  consumer accepts row
rd_out_data  out  ROW_WORDS*DATA_W  streamed row
mem_rd_enable  out  1  to wrapper rd_enable
mem_rd_addr  out  ADDR_W  to wrapper rd_addr
mem_wr_enable  out  1  to wrapper wr_enable
mem_wr_addr  out  ADDR_W  to wrapper wr_addr
mem_wr_data  out  ROW_WORDS*DATA_W  to wrapper wr_data (unpacked per lane at instantiation)
mem_rd_data  in  ROW_WORDS*DATA_W  from wrapper rd_data, valid the cycle after mem_rd_enable

Behaviour:
- Reset, asynchronous on reset low: FSM=IDLE; counters, starve counter, in-flight flag, FIFO cleared. busy, done, rd_out_valid, mem_* enables = 0; wr_req_ready=0 while reset is low. Reset mid-burst discards all in-flight data; no done is produced.
- FSM states IDLE, STREAM, DRAIN.
- IDLE:
  - cfg_start=1 latches base, len, stride.
  - len=0: stay IDLE and pulse done next cycle.
  - Otherwise go to STREAM.
- Read issue: mem_rd_enable=1 when all of the following hold:
  - state=STREAM
  - read grant held
  - FIFO occupancy + inflight < 2
- On each issue: addr += stride (mod 2^ADDR_W, wrap silent); remaining -= 1. At remaining reaching 0, go to DRAIN.
- Read capture: inflight flag set on issue; next cycle mem_rd_data is pushed into the FIFO unconditionally (credit guarantees space).
- DRAIN: when inflight=0 and FIFO empty, pulse done and go to IDLE.
- cfg_start outside IDLE is ignored.
- Output: rd_out_valid = FIFO non-empty; pop on rd_out_valid & rd_out_ready. Push and pop in the same cycle are both allowed.
- Arbitration:
  - IDLE/DRAIN: write granted whenever wr_req_valid.
  - STREAM: the read wins by default. Starve counter increments each cycle wr_req_valid=1 and is not granted. When the counter equals STARVE_MAX, the write is granted for that cycle, the read is not issued, and the counter clears.
  - Counter clears on any write grant; it saturates and never wraps.
- Write grant: mem_wr_enable = wr_req_ready = grant; addr/data pass through combinationally; mem_wr_data = 0 when not granted.
- No read-after-write address hazard checking. The loader must not write rows of an active burst.
- Same-column latency quirk of the wrapper is hidden: rows are always captured exactly 1 cycle after issue.

Decomposition:
- Shared parameters package gets the FSM state enum and the packed row type (ROW_WORDS*DATA_W).
- One sub-module: w_mem_skid_fifo, a 2-entry synchronous FIFO with push/pop/count and the same reset.

Test Plan:
- base=0x010, len=4, stride=4, rd_out_ready=1, no writes -> mem_rd_addr 0x010, 0x014, 0x018, 0x01C on 4 consecutive cycles; rows out 1 cycle later in order; done 1 cycle after the last row pops.
- Same burst with rd_out_ready=0 for 5 cycles -> at most 2 reads issued; rd_out_valid held; no data lost or reordered after release.
- wr_req_valid held throughout a len=20 burst, STARVE_MAX=8 -> write granted on the 9th stalled cycle; mem_rd_enable=0 that cycle; never both enables high.
- len=0 start -> no mem_rd_enable; done pulse next cycle; busy stays 0.
- base=0x3FFC (ADDR_W=14), stride=4, len=2 -> addresses 0x3FFC then 0x0000.
- reset low asserted mid-STREAM with 2 rows buffered -> all outputs 0 immediately; after release, a new cfg_start streams correctly with no stale rows.
